// File: rtl/gtx_pkg.sv
// Shared definitions for the GTX receive link framer: comma symbol, FSM states, defaults.
package gtx_pkg;

    localparam logic [7:0] K28_5        = 8'hBC;
    localparam int         LOCK_CNT_DEF = 4;
    localparam int         ERR_MAX_DEF  = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gtx_lane_align.sv
// Byte-lane realignment: both lane candidates are registered every cycle and lane_i picks one,
// so a lane change in HUNT takes effect without losing the word already in flight.
module gtx_lane_align (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lane_i,
    input  logic [15:0] data_i,
    input  logic [1:0]  ctrl_i,
    output logic [15:0] data_o,
    output logic [1:0]  ctrl_o
);

    logic [7:0]  hi_q;
    logic        khi_q;
    logic [15:0] w0_q;
    logic [1:0]  k0_q;
    logic [15:0] w1_q;
    logic [1:0]  k1_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_q  <= '0;
            khi_q <= 1'b0;
            w0_q  <= '0;
            k0_q  <= '0;
            w1_q  <= '0;
            k1_q  <= '0;
        end else begin
            hi_q  <= data_i[15:8];
            khi_q <= ctrl_i[1];
            w0_q  <= data_i;
            k0_q  <= ctrl_i;
            // lane 1: previous high byte becomes the low byte of the aligned word
            w1_q  <= {data_i[7:0], hi_q};
            k1_q  <= {ctrl_i[0], khi_q};
        end
    end

    assign data_o = lane_i ? w1_q : w0_q;
    assign ctrl_o = lane_i ? k1_q : k0_q;

endmodule

// File: rtl/gtx_link_rx.sv
// 8b/10b receive framer: aligns the comma lane, checks {W0,W1} frames and tracks link lock.
// Frame evaluation happens one cycle after alignment; outputs follow one cycle later.
module gtx_link_rx
    import gtx_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int ERR_MAX    = ERR_MAX_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [1:0]            ctrl_i,
    input  logic [15:0]           data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  link_up_o,
    output logic [15:0]           err_cnt_o,
    output logic                  lane_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_MAX - 1);

    state_e                state_q, state_d;
    logic                  lane_q, lane_d;
    logic                  exp_w1_q, exp_w1_d;
    logic                  first_q, first_d;
    logic [7:0]            seq_q, seq_d;
    logic [7:0]            prev_seq_q, prev_seq_d;
    logic [GW-1:0]         good_cnt_q, good_cnt_d;
    logic [EW-1:0]         bad_cnt_q, bad_cnt_d;
    logic [15:0]           err_q, err_d;
    logic                  upd_q, upd_d;
    logic [DATA_WIDTH-1:0] pay_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  link_up_q;

    logic [15:0] aw;
    logic [1:0]  ak;
    logic        comma_lo, comma_hi, is_w0, w1_bad;
    logic        good_ev, bad_ev;

    gtx_lane_align u_align (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .lane_i  (lane_q),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .data_o  (aw),
        .ctrl_o  (ak)
    );

    assign comma_lo = (ctrl_i == 2'b01) && (data_i[7:0]  == K28_5);
    assign comma_hi = (ctrl_i == 2'b10) && (data_i[15:8] == K28_5);
    assign is_w0    = (ak == 2'b01) && (aw[7:0] == K28_5);
    assign w1_bad   = (ak != 2'b00)
                   || (aw[15:8] != (aw[7:0] ^ seq_q))
                   || (!first_q && (seq_q != 8'(prev_seq_q + 8'd1)));

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        exp_w1_d   = exp_w1_q;
        first_d    = first_q;
        seq_d      = seq_q;
        prev_seq_d = prev_seq_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = err_q;
        upd_d      = 1'b0;
        good_ev    = 1'b0;
        bad_ev     = 1'b0;

        case (state_q)
            HUNT: begin
                if (comma_lo) begin
                    lane_d = 1'b0;
                end else if (comma_hi) begin
                    lane_d = 1'b1;
                end
                if (is_w0) begin
                    state_d    = CHECK;
                    seq_d      = aw[15:8];
                    exp_w1_d   = 1'b1;
                    first_d    = 1'b1;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            end
            CHECK, LOCKED: begin
                if (exp_w1_q) begin
                    exp_w1_d = 1'b0;
                    good_ev  = !w1_bad;
                    bad_ev   = w1_bad;
                end else if (is_w0) begin
                    seq_d    = aw[15:8];
                    exp_w1_d = 1'b1;
                end else begin
                    bad_ev = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (good_ev) begin
            prev_seq_d = seq_q;
            first_d    = 1'b0;
            bad_cnt_d  = '0;
            if (state_q == LOCKED) begin
                upd_d = 1'b1;
            end else if (good_cnt_q == LOCK_LAST) begin
                state_d = LOCKED;
                upd_d   = 1'b1;
            end else begin
                good_cnt_d = good_cnt_q + GW'(1);
            end
        end

        if (bad_ev) begin
            if (state_q == LOCKED) begin
                err_d = sat_inc16(err_q);
                if (bad_cnt_q == ERR_LAST) begin
                    state_d = HUNT;
                end else begin
                    bad_cnt_d = bad_cnt_q + EW'(1);
                end
            end else begin
                state_d = HUNT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= HUNT;
            lane_q     <= 1'b0;
            exp_w1_q   <= 1'b0;
            first_q    <= 1'b0;
            seq_q      <= '0;
            prev_seq_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_q      <= '0;
            upd_q      <= 1'b0;
            pay_q      <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            exp_w1_q   <= exp_w1_d;
            first_q    <= first_d;
            seq_q      <= seq_d;
            prev_seq_q <= prev_seq_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_q      <= err_d;
            upd_q      <= upd_d;
            if (upd_d) begin
                pay_q <= aw[DATA_WIDTH-1:0];
            end
        end
    end

    // Output stage: the extra register lines valid_o up with link_up_o
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            valid_q   <= upd_q;
            link_up_q <= (state_q == LOCKED);
            if (upd_q) begin
                data_q <= pay_q;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign link_up_o = link_up_q;
    assign err_cnt_o = err_q;
    assign lane_o    = lane_q;

endmodule

// File: tb/tb_gtx_link_rx.sv
// Directed bench for gtx_link_rx: a per-cycle vector table plus byte-stream scenarios.
module tb_gtx_link_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [15:0] din;
    logic [0:0]  dout;
    logic        valid, link, lane;
    logic [15:0] err;

    always #5 clk = ~clk;

    gtx_link_rx dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .ctrl_i    (ctrl),
        .data_i    (din),
        .data_o    (dout),
        .valid_o   (valid),
        .link_up_o (link),
        .err_cnt_o (err),
        .lane_o    (lane)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        v;
        logic        l;
        logic        dat;
        logic        ln;
        logic [15:0] e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  bq[$];
    logic        kq[$];
    logic        vlog[64];
    logic        llog[64];
    logic        dlog[64];
    logic        nlog[64];
    logic [15:0] elog[64];
    int          nw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] d, input logic [1:0] k);
        din  = d;
        ctrl = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        din   = '0;
        ctrl  = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_b(input logic [7:0] b, input logic k);
        bq.push_back(b);
        kq.push_back(k);
    endtask

    task automatic add_frame(input logic [7:0] s, input logic [7:0] p, input bit bad);
        add_b(8'hBC, 1'b1);
        add_b(s, 1'b0);
        add_b(p, 1'b0);
        add_b(bad ? (p ^ s ^ 8'hFF) : (p ^ s), 1'b0);
    endtask

    task automatic run_stream();
        if (bq.size() % 2 != 0) add_b(8'h00, 1'b0);
        nw = bq.size() / 2;
        for (int i = 0; i < 64; i++) begin
            vlog[i] = 1'b0; llog[i] = 1'b0; dlog[i] = 1'b0; nlog[i] = 1'b0; elog[i] = '0;
        end
        for (int i = 0; i < nw; i++) begin
            step({bq[2*i+1], bq[2*i]}, {kq[2*i+1], kq[2*i]});
            vlog[i] = valid;
            llog[i] = link;
            dlog[i] = dout[0];
            nlog[i] = lane;
            elog[i] = err;
        end
        bq.delete();
        kq.delete();
    endtask

    function automatic int vcount(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (vlog[i]) c++;
        return c;
    endfunction

    vec_t tbl[12];

    initial begin
        // lane-0 stream, payload 1, seq 0..4, then two idle words
        tbl[0]  = '{16'h00BC, 2'b01, 0, 0, 0, 0, 16'd0};
        tbl[1]  = '{16'h0101, 2'b00, 0, 0, 0, 0, 16'd0};
        tbl[2]  = '{16'h01BC, 2'b01, 0, 0, 0, 0, 16'd0};
        tbl[3]  = '{16'h0001, 2'b00, 0, 0, 0, 0, 16'd0};
        tbl[4]  = '{16'h02BC, 2'b01, 0, 0, 0, 0, 16'd0};
        tbl[5]  = '{16'h0301, 2'b00, 0, 0, 0, 0, 16'd0};
        tbl[6]  = '{16'h03BC, 2'b01, 0, 0, 0, 0, 16'd0};
        tbl[7]  = '{16'h0201, 2'b00, 0, 0, 0, 0, 16'd0};
        tbl[8]  = '{16'h04BC, 2'b01, 0, 0, 0, 0, 16'd0};
        tbl[9]  = '{16'h0501, 2'b00, 1, 1, 1, 0, 16'd0};
        tbl[10] = '{16'h0000, 2'b00, 0, 1, 1, 0, 16'd0};
        tbl[11] = '{16'h0000, 2'b00, 1, 1, 1, 0, 16'd1};

        rst_n = 1'b0;
        din   = '0;
        ctrl  = '0;
        #1;
        chk("rst_data", 32'(dout), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_link", 32'(link), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_lane", 32'(lane), 0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].d, tbl[i].k);
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_link", i), 32'(link), 32'(tbl[i].l));
            chk($sformatf("tbl%0d_data", i), 32'(dout), 32'(tbl[i].dat));
            chk($sformatf("tbl%0d_lane", i), 32'(lane), 32'(tbl[i].ln));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e));
        end

        // lane-1: same frames shifted by one byte
        do_reset();
        add_b(8'h00, 1'b0);
        for (int f = 0; f < 5; f++) add_frame(8'(f), 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) add_b(8'h00, 1'b0);
        run_stream();
        chk("l1_link_before", 32'(llog[9]), 0);
        chk("l1_link_up", 32'(llog[10]), 1);
        chk("l1_valid_a", 32'(vlog[10]), 1);
        chk("l1_valid_b", 32'(vlog[12]), 1);
        chk("l1_valid_cnt", 32'(vcount(0, 12)), 2);
        chk("l1_lane", 32'(nlog[10]), 1);
        chk("l1_data", 32'(dlog[12]), 1);

        // LOCKED: 3 bad chk, 1 good, then 4 bad
        do_reset();
        for (int f = 0; f < 4; f++) add_frame(8'(f), 8'h01, 1'b0);
        for (int f = 0; f < 3; f++) add_frame(8'h04, 8'h01, 1'b1);
        add_frame(8'h04, 8'h02, 1'b0);
        for (int f = 0; f < 4; f++) add_frame(8'h05, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) add_b(8'h00, 1'b0);
        run_stream();
        chk("err_lock_valid", 32'(vlog[9]), 1);
        chk("err_good_valid", 32'(vlog[17]), 1);
        chk("err_valid_cnt", 32'(vcount(0, 25)), 2);
        chk("err_cnt3", 32'(elog[17]), 3);
        chk("err_link_kept", 32'(llog[17]), 1);
        chk("err_data_upd", 32'(dlog[17]), 0);
        chk("err_link_3bad", 32'(llog[23]), 1);
        chk("err_cnt7", 32'(elog[24]), 7);
        chk("err_link_drop", 32'(llog[25]), 0);
        chk("err_cnt7_hold", 32'(elog[25]), 7);

        // CHECK with seq jump 1 -> 3 must restart from HUNT
        do_reset();
        add_frame(8'h00, 8'h01, 1'b0);
        add_frame(8'h01, 8'h01, 1'b0);
        for (int s = 3; s <= 7; s++) add_frame(8'(s), 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) add_b(8'h00, 1'b0);
        run_stream();
        chk("jump_no_valid", 32'(vcount(0, 14)), 0);
        chk("jump_no_link", 32'(llog[14]), 0);
        chk("jump_relock_valid", 32'(vlog[15]), 1);
        chk("jump_relock_link", 32'(llog[15]), 1);

        // ctrl 2'b11 in HUNT must not move the lane
        do_reset();
        step(16'hBC00, 2'b10);
        chk("k11_lane_set", 32'(lane), 1);
        for (int i = 0; i < 4; i++) step(16'hBCBC, 2'b11);
        chk("k11_lane_kept", 32'(lane), 1);
        chk("k11_link", 32'(link), 0);
        chk("k11_valid", 32'(valid), 0);

        // async reset mid-W1 while LOCKED on lane 1, then relock on lane 0
        do_reset();
        add_b(8'h00, 1'b0);
        for (int f = 0; f < 4; f++) add_frame(8'(f), 8'h01, 1'b0);
        add_frame(8'h04, 8'h01, 1'b1);
        add_frame(8'h04, 8'h03, 1'b0);
        add_b(8'hBC, 1'b1);
        add_b(8'h05, 1'b0);
        add_b(8'h01, 1'b0);
        run_stream();
        chk("pre_rst_link", 32'(link), 1);
        chk("pre_rst_lane", 32'(lane), 1);
        chk("pre_rst_err", 32'(err), 1);
        chk("pre_rst_data", 32'(dout), 1);
        din   = 16'h0004;
        ctrl  = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(dout), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_link", 32'(link), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_lane", 32'(lane), 0);
        @(posedge clk);
        @(negedge clk);
        chk("arst_valid_held", 32'(valid), 0);
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) add_frame(8'(10 + f), 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) add_b(8'h00, 1'b0);
        run_stream();
        chk("relock_before", 32'(llog[8]), 0);
        chk("relock_link", 32'(llog[9]), 1);
        chk("relock_valid", 32'(vlog[9]), 1);
        chk("relock_valid_cnt", 32'(vcount(0, 9)), 1);
        chk("relock_lane", 32'(nlog[9]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gtx_link_rx.md
GTX_LINK_RX -- requirements
Module: gtx_link_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, giving the payload bits forwarded to data_o (1..8).
REQ-002 SHALL have parameter LOCK_CNT, default 4, giving the consecutive good frames needed to declare link up.
REQ-003 SHALL have parameter ERR_MAX, default 4, giving the consecutive bad frames that drop the link.
REQ-004 SHALL have port clk_i  input  1  receive user clock (rxusrclk2 domain); the block has one clock.
REQ-005 SHALL have port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port ctrl_i  input  2  per-byte K-flags; bit0 = data_i[7:0], bit1 = data_i[15:8].
REQ-007 SHALL have port data_i  input  16  decoded 8b/10b receive word.
REQ-008 SHALL have port data_o  output  DATA_WIDTH  last good payload, payload[DATA_WIDTH-1:0].
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse on each data_o update.
REQ-010 SHALL have port link_up_o  output  1  high while the FSM is LOCKED.
REQ-011 SHALL have port err_cnt_o  output  16  saturating count of bad frames seen while LOCKED.
REQ-012 SHALL have port lane_o  output  1  comma byte lane in use (0 = low byte, 1 = high byte).

Function
REQ-013 SHALL use a frame of two aligned words: W0 = {seq[7:0], K28.5 8'hBC} with K-flags 2'b01; W1 = {chk[7:0], payload[7:0]} with K-flags 2'b00, where chk = payload XOR seq.
REQ-014 SHALL align words as follows: lane 0 passes data_i/ctrl_i through registered; lane 1 forms the aligned word from {current low byte, previous high byte}, with K-flags aligned the same way; alignment latency is 1 cycle in both lanes.
REQ-015 SHALL, in HUNT, take a comma in exactly one lane (ctrl_i 2'b01 with low byte 8'hBC, or 2'b10 with high byte 8'hBC) to set the lane; ctrl_i 2'b11 SHALL be ignored.
REQ-016 SHALL NOT change the lane outside HUNT.
REQ-017 SHALL classify a frame as bad on any of: W1 with any K-flag set; chk mismatch; seq not equal to previous good seq+1 mod 256; no W0 where one is expected (the aligned word following W1 is not a comma).
REQ-018 SHALL skip the seq check for the first frame after leaving HUNT.
REQ-019 SHALL run the FSM: HUNT -> CHECK on a valid W0.
REQ-020 SHALL, in CHECK, go to LOCKED after LOCK_CNT consecutive good frames, and go to HUNT on any bad frame.
REQ-021 SHALL, in LOCKED, clear the bad-run count on a good frame and go to HUNT after ERR_MAX consecutive bad frames.
REQ-022 SHALL update data_o and pulse valid_o only for good frames while LOCKED, including the good frame that completes CHECK; otherwise data_o holds its value.
REQ-023 SHALL assert valid_o exactly 2 clk_i cycles after the edge that samples the last byte of W1 on data_i.
REQ-024 SHALL drive link_up_o from a register, high in the cycle after entry to LOCKED and low in the cycle after exit.
REQ-025 SHALL increment err_cnt_o per bad frame in LOCKED and saturate it at 16'hFFFF; it is not cleared on link loss.

Reset
REQ-026 SHALL, while rst_n_i is low, immediately force: FSM = HUNT, data_o = 0, valid_o = 0, link_up_o = 0, err_cnt_o = 0, lane_o = 0, and all counters and pipeline registers = 0.
REQ-027 SHALL, on reset asserted mid-frame, discard any partial frame; after release, decoding restarts from HUNT.

Structure
REQ-028 SHALL take from shared package gtx_pkg: constant K28_5 (8'hBC), the state enum (HUNT, CHECK, LOCKED), and the default LOCK_CNT/ERR_MAX values.
REQ-029 SHALL implement byte-lane realignment (REQ-014) as sub-module gtx_lane_align, instantiated once.

Verification
REQ-030 SHALL cover: lane-0 stream of 5 good frames seq 0..4, payload 8'h01 -> link_up_o rises after frame 4, data_o = 1, one valid_o pulse on frame 4 and one on frame 5.
REQ-031 SHALL cover: same stream shifted one byte (lane 1) -> lane_o = 1, identical link-up timing and data_o.
REQ-032 SHALL cover: LOCKED, then 3 bad chk frames and 1 good -> link stays up, err_cnt_o = 3; then 4 bad -> link_up_o low, err_cnt_o = 7.
REQ-033 SHALL cover: CHECK with seq jump 1 -> 3 -> FSM returns to HUNT, no valid_o pulse.
REQ-034 SHALL cover: ctrl_i 2'b11 with both bytes 8'hBC in HUNT -> stays HUNT, lane_o unchanged.
REQ-035 SHALL cover: rst_n_i pulse mid-W1 while LOCKED -> all outputs 0 asynchronously; relock after LOCK_CNT frames.
